// File: rtl/demux5_buf_if.sv
// Bus bundle for demux5_buf: producer-side offer/ready plus the five buffered
// consumer channels and the transfer counter.
interface demux5_buf_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
);
    logic [2:0]       selector;
    logic [WIDTH-1:0] data_in;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] data_out_0;
    logic [WIDTH-1:0] data_out_1;
    logic [WIDTH-1:0] data_out_2;
    logic [WIDTH-1:0] data_out_3;
    logic [WIDTH-1:0] data_out_4;
    logic [4:0]       out_valid;
    logic [4:0]       out_ack;
    logic [CNT_W-1:0] xfer_count;

    modport master (
        output selector, data_in, in_valid, out_ack,
        input  in_ready, data_out_0, data_out_1, data_out_2, data_out_3, data_out_4,
        input  out_valid, xfer_count
    );

    modport slave (
        input  selector, data_in, in_valid, out_ack,
        output in_ready, data_out_0, data_out_1, data_out_2, data_out_3, data_out_4,
        output out_valid, xfer_count
    );
endinterface

// File: rtl/demux5_buf.sv
// One-to-five demultiplexer with a one-entry buffer per channel, broadcast on
// selector 111, and a saturating count of accepted transfers.
module demux5_buf #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input logic         clk,
    input logic         reset,
    demux5_buf_if.slave bus
);
    logic [4:0]       can_take;
    logic [4:0]       dest;
    logic [4:0]       load;
    logic             in_ready;
    logic             accept;
    logic [WIDTH-1:0] data_q [5];
    logic [WIDTH-1:0] data_d [5];
    logic [4:0]       valid_q;
    logic [4:0]       valid_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign can_take = ~valid_q | bus.out_ack;

    always_comb begin
        dest = 5'b00001;
        case (bus.selector)
            3'd0:    dest = 5'b00001;
            3'd1:    dest = 5'b00010;
            3'd2:    dest = 5'b00100;
            3'd3:    dest = 5'b01000;
            3'd4:    dest = 5'b10000;
            3'd5:    dest = 5'b00001;
            3'd6:    dest = 5'b00001;
            3'd7:    dest = 5'b11111;
            default: dest = 5'b00001;
        endcase
    end

    // Ready only when every addressed channel can take; covers unicast and broadcast alike.
    assign in_ready = ((dest & can_take) == dest);
    assign accept   = bus.in_valid & in_ready;
    assign load     = accept ? dest : 5'b00000;

    always_comb begin
        valid_d = (valid_q & ~bus.out_ack) | load;
        for (int k = 0; k < 5; k++) begin
            data_d[k] = load[k] ? bus.data_in : data_q[k];
        end
        cnt_d = cnt_q;
        if (accept && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 5'b00000;
            cnt_q   <= '0;
            for (int k = 0; k < 5; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            for (int k = 0; k < 5; k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = valid_q;
    assign bus.xfer_count = cnt_q;
    assign bus.data_out_0 = data_q[0];
    assign bus.data_out_1 = data_q[1];
    assign bus.data_out_2 = data_q[2];
    assign bus.data_out_3 = data_q[3];
    assign bus.data_out_4 = data_q[4];
endmodule

// File: doc/demux5_buf.md
DEMUX5_BUF -- requirements
Module: demux5_buf

Interface
REQ-001 Parameter WIDTH, default 32, data width of the input word and of every output channel.
REQ-002 Parameter CNT_W, default 16, width of the transfer counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 selector  input  3  destination code: 000-100 select channel 0-4; 101 and 110 select channel 0; 111 is broadcast.
REQ-006 data_in  input  WIDTH  word to be delivered.
REQ-007 in_valid  input  1  producer offers data_in/selector this cycle.
REQ-008 in_ready  output  1  block accepts the offer this cycle (combinational).
REQ-009 data_out_0 .. data_out_4  output  WIDTH each  held word of channel 0-4 (registered).
REQ-010 out_valid  output  5  bit k set = channel k holds an undelivered word (registered).
REQ-011 out_ack  input  5  bit k = consumer k takes data_out_k this cycle.
REQ-012 xfer_count  output  CNT_W  number of accepted input transfers, saturating (registered).

Function
REQ-013 Each channel k shall be a one-entry buffer: data_out_k register plus out_valid[k] flag.
REQ-014 Channel k "can take" in a cycle when out_valid[k]=0 or out_ack[k]=1.
REQ-015 For unicast codes, in_ready shall equal "can take" of the decoded channel; selector 101/110 decodes to channel 0.
REQ-016 For selector 111, in_ready shall be 1 only when all five channels can take.
REQ-017 in_ready shall depend only on selector, out_valid and out_ack, never on in_valid.
REQ-018 Accept = in_valid & in_ready; on accept the destination channel(s) shall load data_in and set out_valid at the next edge (1-cycle latency).
REQ-019 out_ack[k] with out_valid[k]=1 and no load to k shall clear out_valid[k]; data_out_k shall hold its last value.
REQ-020 out_ack[k] with out_valid[k]=0 shall be ignored.
REQ-021 Simultaneous ack and load on channel k: data_out_k takes the new word and out_valid[k] stays 1 (no bubble).
REQ-022 Without accept, data_out_k shall not change while out_valid[k]=1.
REQ-023 in_valid=1 with in_ready=0 shall cause no state change; producer holds data_in/selector stable until accepted.
REQ-024 xfer_count shall increment by 1 per accept (broadcast counts as 1) and saturate at 2^CNT_W-1.
REQ-025 Channels not addressed by an accept shall be unaffected, including their ack processing in the same cycle.

Reset
REQ-026 reset=0 shall immediately (asynchronously) force out_valid=00000, all data_out_k=0, xfer_count=0.
REQ-027 Reset asserted mid-transfer shall discard buffered words; no channel reports valid after release.
REQ-028 in_ready shall be driven per REQ-015/016 from the reset state (1 for any selector) while reset=0 is released and no acks pending; no accept is registered while reset=0.

Verification
REQ-029 After reset, selector=010, data_in=0xDEADBEEF, in_valid=1 one cycle -> next cycle out_valid=00100, data_out_2=0xDEADBEEF, xfer_count=1.
REQ-030 Channel 2 full, no ack, second offer to 010 -> in_ready=0, data_out_2 unchanged, xfer_count unchanged; assert out_ack[2] same cycle -> in_ready=1, new word loaded, out_valid[2] stays 1.
REQ-031 selector=110, data_in=0x00000055, accept -> out_valid=00001, data_out_0=0x00000055.
REQ-032 Channel 4 full, selector=111 offer -> in_ready=0; ack channel 4 same cycle -> accept, all five data_out=data_in, out_valid=11111, xfer_count +1.
REQ-033 CNT_W=4, 20 consecutive accepts with all channels acked each cycle -> xfer_count stops at 15.
REQ-034 Load channels 1 and 3, pulse reset=0 between clock edges -> out_valid=00000, data_out_1=data_out_3=0, xfer_count=0 before next edge.
